// File: rtl/roulette_wheel_spinner.sv
// Roulette wheel spinner: free-running LFSR entropy, a decelerating wheel animation,
// and a settled result presented to the game FSMs with a valid/ack handshake.
module roulette_wheel_spinner #(
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          NUM_SLOTS     = 32,
  parameter int          NUM_STEPS     = 16,
  parameter int          BASE_INTERVAL = 4,
  parameter int          INTERVAL_INC  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spin_req,
  input  logic       result_ack,
  output logic [4:0] randnum,
  output logic       result_valid,
  output logic       is_even,
  output logic       busy,
  output logic [4:0] position,
  output logic       step_pulse,
  output logic [1:0] fsm_state
);

  // Handshake: result_valid rises with a fresh randnum and stays high, with randnum
  // stable, until result_ack is seen high at a clock edge; it is low the next cycle.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SPIN = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [4:0]  LAST_SLOT = 5'(NUM_SLOTS - 1);
  localparam logic [5:0]  SLOTS6    = 6'(NUM_SLOTS);
  localparam logic [15:0] BASE16    = 16'(BASE_INTERVAL);
  localparam logic [15:0] INC16     = 16'(INTERVAL_INC);
  localparam logic [15:0] STEPS16   = 16'(NUM_STEPS);

  logic [1:0]  state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic        spin_req_d;
  logic        start;
  logic [15:0] steps_left;
  logic [15:0] interval;
  logic [15:0] counter;
  logic [4:0]  start_pos;
  logic [4:0]  next_pos;
  logic        step_now;

  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign start     = spin_req & ~spin_req_d & (state == ST_IDLE);

  // Folding the raw 5-bit value once is enough because NUM_SLOTS is at least 16.
  assign start_pos = ({1'b0, lfsr[4:0]} < SLOTS6) ? lfsr[4:0]
                                                  : 5'({1'b0, lfsr[4:0]} - SLOTS6);
  assign next_pos  = (position == LAST_SLOT) ? 5'd0 : position + 5'd1;
  assign step_now  = (counter == interval - 16'd1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      lfsr         <= SEED_EFF;
      spin_req_d   <= 1'b0;
      randnum      <= 5'd0;
      result_valid <= 1'b0;
      position     <= 5'd0;
      step_pulse   <= 1'b0;
      steps_left   <= 16'd0;
      interval     <= 16'd0;
      counter      <= 16'd0;
    end else begin
      lfsr       <= lfsr_next;
      spin_req_d <= spin_req;
      step_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            position   <= start_pos;
            steps_left <= STEPS16 + {13'd0, lfsr[7:5]};
            interval   <= BASE16;
            counter    <= 16'd0;
            state      <= ST_SPIN;
          end
        end
        ST_SPIN: begin
          if (step_now) begin
            position   <= next_pos;
            step_pulse <= 1'b1;
            steps_left <= steps_left - 16'd1;
            interval   <= interval + INC16;
            counter    <= 16'd0;
            if (steps_left == 16'd1) begin
              randnum      <= next_pos;
              result_valid <= 1'b1;
              state        <= ST_HOLD;
            end
          end else begin
            counter <= counter + 16'd1;
          end
        end
        ST_HOLD: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state == ST_SPIN);
  assign is_even   = ~randnum[0];
  assign fsm_state = state;

endmodule

// File: tb/tb_roulette_wheel_spinner.sv
// Bench for roulette_wheel_spinner: two instances (32 and 20 slots) share stimulus
// and are checked every cycle against a closed-form spin model plus literal values.
module tb_roulette_wheel_spinner;

  localparam int B   = 4;
  localparam int INC = 2;
  localparam int NS  = 16;

  logic clk;
  logic reset_n;
  logic spin_req;
  logic result_ack;
  logic [4:0] randnum [2];
  logic       result_valid [2];
  logic       is_even [2];
  logic       busy [2];
  logic [4:0] position [2];
  logic       step_pulse [2];
  logic [1:0] fsm_state [2];

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  roulette_wheel_spinner #(.NUM_SLOTS(32)) dut0 (
    .clk(clk), .reset_n(reset_n), .spin_req(spin_req), .result_ack(result_ack),
    .randnum(randnum[0]), .result_valid(result_valid[0]), .is_even(is_even[0]),
    .busy(busy[0]), .position(position[0]), .step_pulse(step_pulse[0]),
    .fsm_state(fsm_state[0]));

  roulette_wheel_spinner #(.NUM_SLOTS(20)) dut1 (
    .clk(clk), .reset_n(reset_n), .spin_req(spin_req), .result_ack(result_ack),
    .randnum(randnum[1]), .result_valid(result_valid[1]), .is_even(is_even[1]),
    .busy(busy[1]), .position(position[1]), .step_pulse(step_pulse[1]),
    .fsm_state(fsm_state[1]));

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Cycle at which step k completes, counted in clock edges after the start edge.
  function automatic int step_time(input int k);
    return k * B + INC * k * (k - 1) / 2;
  endfunction

  int          slots [2] = '{32, 20};
  logic [15:0] m_lfsr;
  bit          m_req_d;
  bit          m_started = 0;
  int          m_mode [2];   // 0 idle, 1 spinning, 2 holding a result
  int          m_t [2];
  int          m_p0 [2];
  int          m_s [2];
  int          m_pos [2];
  int          m_rand [2];
  bit          m_valid [2];
  bit          m_pulse [2];

  always @(posedge clk) begin
    logic [15:0] l;
    int k;
    m_started = 1;
    if (!reset_n) begin
      m_lfsr  = 16'hACE1;
      m_req_d = 0;
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0; m_pos[i] = 0; m_rand[i] = 0; m_valid[i] = 0; m_pulse[i] = 0;
      end
    end else begin
      l = m_lfsr;
      m_lfsr = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
      for (int i = 0; i < 2; i++) begin
        m_pulse[i] = 0;
        if (m_mode[i] == 0) begin
          if (spin_req && !m_req_d) begin
            m_p0[i]   = int'(l[4:0]) % slots[i];
            m_s[i]    = NS + int'(l[7:5]);
            m_t[i]    = 0;
            m_pos[i]  = m_p0[i];
            m_mode[i] = 1;
          end
        end else if (m_mode[i] == 1) begin
          m_t[i]++;
          k = 0;
          while (k < m_s[i] && step_time(k + 1) <= m_t[i]) k++;
          m_pos[i]   = (m_p0[i] + k) % slots[i];
          m_pulse[i] = (k > 0) && (step_time(k) == m_t[i]);
          if (k == m_s[i]) begin
            m_rand[i]  = m_pos[i];
            m_valid[i] = 1;
            m_mode[i]  = 2;
          end
        end else begin
          if (result_ack) begin
            m_valid[i] = 0;
            m_mode[i]  = 0;
          end
        end
      end
      m_req_d = spin_req;
    end
  end

  // ---------------- compare process (every cycle) ----------------
  always @(negedge clk) begin
    if (m_started) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("d%0d_randnum", i), int'(randnum[i]), m_rand[i]);
        check($sformatf("d%0d_valid", i), int'(result_valid[i]), int'(m_valid[i]));
        check($sformatf("d%0d_is_even", i), int'(is_even[i]), int'(m_rand[i] % 2 == 0));
        check($sformatf("d%0d_busy", i), int'(busy[i]), int'(m_mode[i] == 1));
        check($sformatf("d%0d_position", i), int'(position[i]), m_pos[i]);
        check($sformatf("d%0d_step_pulse", i), int'(step_pulse[i]), int'(m_pulse[i]));
      end
    end
  end

  // ---------------- activity monitor ----------------
  int  busy_total  = 0;
  int  pulse_total = 0;
  bit  saw_wrap    = 0;
  logic [4:0] prev_pos1 = 5'd0;

  always @(negedge clk) begin
    if (busy[0]) busy_total++;
    if (step_pulse[0]) pulse_total++;
    if (prev_pos1 == 5'd19 && position[1] == 5'd0 && step_pulse[1]) saw_wrap = 1;
    prev_pos1 = position[1];
  end

  // ---------------- driver tasks ----------------
  task automatic wait_valid(input int max_cycles, input string name);
    int n = 0;
    while (!result_valid[0] && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (!result_valid[0]) begin
      n_fail++;
      $display("FAIL %s: result_valid still 0 after %0d cycles, required 1", name, max_cycles);
    end
  endtask

  task automatic ack_pulse();
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b0;
    int p0;
    reset_n = 1'b0; spin_req = 1'b0; result_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_randnum", int'(randnum[0]), 0);
    check("rst_valid", int'(result_valid[0]), 0);
    check("rst_is_even", int'(is_even[0]), 1);
    check("rst_busy", int'(busy[0]), 0);
    check("rst_position", int'(position[0]), 0);
    check("rst_step_pulse", int'(step_pulse[0]), 0);

    // Deterministic spin from the seed, with request toggles while spinning.
    b0 = busy_total; p0 = pulse_total;
    reset_n = 1'b1; spin_req = 1'b1;
    repeat (50) @(negedge clk);
    spin_req = 1'b0; @(negedge clk);
    spin_req = 1'b1; @(negedge clk);
    spin_req = 1'b0; @(negedge clk);
    spin_req = 1'b1;
    wait_valid(1000, "spin1_done");
    @(negedge clk);
    check("spin1_busy_cycles", busy_total - b0, 598);
    check("spin1_pulses", pulse_total - p0, 23);
    check("spin1_randnum", int'(randnum[0]), 24);
    check("spin1_is_even", int'(is_even[0]), 1);
    check("wrap_randnum", int'(randnum[1]), 4);
    check("wrap_is_even", int'(is_even[1]), 1);
    check("wrap_seen", int'(saw_wrap), 1);

    // Hold without ack, toggling requests, then ack coinciding with a new edge.
    for (int c = 0; c < 100; c++) begin
      if (c % 10 == 0) spin_req = ~spin_req;
      @(negedge clk);
    end
    check("hold_valid", int'(result_valid[0]), 1);
    check("hold_randnum", int'(randnum[0]), 24);
    spin_req = 1'b0; @(negedge clk);
    spin_req = 1'b1; result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    check("ack_valid_low", int'(result_valid[0]), 0);
    repeat (5) @(negedge clk);
    check("no_restart_busy", int'(busy[0]), 0);
    check("no_extra_pulses", pulse_total - p0, 23);
    check("idle_keeps_randnum", int'(randnum[0]), 24);

    // Fresh spin on a new edge.
    spin_req = 1'b0; @(negedge clk);
    spin_req = 1'b1; @(negedge clk);
    check("fresh_busy", int'(busy[0]), 1);
    wait_valid(1000, "spin2_done");
    @(negedge clk);
    ack_pulse();
    repeat (2) @(negedge clk);

    // Reset in the middle of a spin.
    spin_req = 1'b0; @(negedge clk);
    spin_req = 1'b1;
    repeat (300) @(negedge clk);
    check("mid_busy_before", int'(busy[0]), 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", int'(result_valid[0]), 0);
    check("mid_rst_busy", int'(busy[0]), 0);
    check("mid_rst_position", int'(position[0]), 0);
    check("mid_rst_randnum", int'(randnum[0]), 0);
    reset_n = 1'b1;
    wait_valid(1000, "replay_done");
    @(negedge clk);
    check("replay_randnum", int'(randnum[0]), 24);
    check("replay_wrap_randnum", int'(randnum[1]), 4);
    ack_pulse();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/roulette_wheel_spinner.md
Name: roulette_wheel_spinner

Overview:
Producer side of the game's random-number interface: generates the spun wheel number consumed by the roulette game FSMs on randnum.
- Free-running 16-bit LFSR supplies entropy.
- On a spin request, animates a decelerating wheel and settles on a slot.
- Presents the settled result with a valid/ack handshake and an even/odd flag for the even/odd game.

Parameters:
- LFSR_SEED, 16'hACE1, LFSR reset value; 16'h0000 is replaced by 16'h0001.
- NUM_SLOTS, 32, number of wheel slots, legal range 16..32; results are 0..NUM_SLOTS-1.
- NUM_STEPS, 16, minimum slot advances per spin.
- BASE_INTERVAL, 4, clock cycles per step for the first step; must be at least 1.
- INTERVAL_INC, 2, cycles added to the interval after each step (deceleration).

Ports:
- Clock  input  1  system clock; all logic on posedge.
- reset_n  input  1  reset, synchronous, active-low.
- spin_req  input  1  spin request level; a rising edge starts a spin.
- result_ack  input  1  consumer has taken result; sampled only in HOLD.
- randnum  output  5  settled wheel number; held until the next settle.
- result_valid  output  1  randnum is new and unacknowledged.
- is_even  output  1  equals ~randnum[0].
- busy  output  1  high in SPIN.
- position  output  5  current wheel slot, for HEX animation.
- step_pulse  output  1  one-cycle pulse on every slot advance.

Behaviour:
Reset (reset_n low at posedge):
- State goes to IDLE and the LFSR loads the seed.
- Outputs: randnum=0, result_valid=0, is_even=1, busy=0, position=0, step_pulse=0.
- spin_req_d=0 and all counters=0.
- Reset mid-SPIN or mid-HOLD aborts immediately; no result is produced.

LFSR:
- Galois, right shift, taps mask 16'hB400.
- Advances every cycle while not in reset. The first post-reset cycle holds the seed; the next holds 16'hE270 for the default seed.

Edge detect:
- spin_req_d registers spin_req.
- start = spin_req & ~spin_req_d & (state==IDLE).
- Edges in SPIN or HOLD are ignored and not queued.

States:
- IDLE
  - On start, capture from the current LFSR value L:
    - position = L[4:0] if L[4:0] < NUM_SLOTS, else L[4:0]-NUM_SLOTS.
    - steps_left = NUM_STEPS + L[7:5].
    - interval = BASE_INTERVAL; interval counter = 0.
  - Next state SPIN; busy=1 from the next cycle.
- SPIN
  - The counter increments each cycle. When counter == interval-1:
    - position advances by 1, wrapping from NUM_SLOTS-1 to 0.
    - step_pulse=1 for that cycle.
    - steps_left decrements; interval += INTERVAL_INC; counter resets to 0.
  - When the step taking steps_left from 1 to 0 occurs, in the same cycle:
    - randnum = new position; result_valid=1; busy=0; go to HOLD.
  - SPIN duration for S steps = S*BASE_INTERVAL + INTERVAL_INC*S*(S-1)/2 cycles.
  - Internal counters are 16 bits wide.
- HOLD
  - result_valid stays 1 and randnum is stable.
  - result_ack=1 gives result_valid=0 next cycle and returns to IDLE.
  - A spin_req edge in the same cycle as ack is discarded; the consumer must re-raise spin_req.
- IDLE after HOLD
  - randnum and position keep the last result; is_even tracks randnum.

Arithmetic:
- Position wraps with a compare, not a modulo.
- steps_left is at most NUM_STEPS+7.
- No overflow is possible with legal parameters.

Test Plan:
- Reset values: hold reset_n=0 for 3 cycles -> randnum=0, result_valid=0, is_even=1, busy=0, position=0, step_pulse=0.
- Deterministic spin, defaults: spin_req=1 in the first post-reset cycle (L=16'hACE1) -> start position 1, S=23, busy for 598 cycles, 23 step_pulses, randnum=24, is_even=1, result_valid=1 until ack.
- Wrap with NUM_SLOTS=20, same stimulus -> start 1, position passes 19->0, randnum=4, is_even=1.
- Handshake:
  - Hold result_ack=0 for 100 cycles -> result_valid stays 1 and randnum stable.
  - Pulse ack -> result_valid=0 next cycle, state IDLE.
  - A new spin_req edge then starts a fresh spin.
- Ignored requests: toggle spin_req during SPIN and HOLD, including in the same cycle as ack -> no restart, no extra spin, step count still 23.
- Mid-operation reset: assert reset_n=0 at cycle 300 of a spin -> all outputs at reset values next cycle, no result_valid. The replayed first-cycle spin again yields 24.
